pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage in-order core. It drives the en/flush pair of the four inter-stage pipeline registers (F/D, D/E, E/M, M/W) and the PC enable. It resolves load-use, multi-cycle mul/div, and instruction/data memory stalls. It also sequences control-flow redirects: branch with delay slot, and exceptions. Redirects are held pending while an instruction fetch is outstanding, and the stale fetch response is dropped.

---
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the
// stall/flush sequencer.
interface pipe_hazard_ctrl_if;
    logic        i_busy;
    logic        i_data_ok;
    logic        d_busy;
    logic        md_busy;
    logic        e_is_load;
    logic [4:0]  e_dst;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic        d_use_rs;
    logic        d_use_rt;
    logic        d_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [31:0] exc_vector;
    logic        en_pc;
    logic        en_fd;
    logic        en_de;
    logic        en_em;
    logic        en_mw;
    logic        flush_fd;
    logic        flush_de;
    logic        flush_em;
    logic        flush_mw;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        drop_fetch;

    modport master (
        output i_busy, i_data_ok, d_busy, md_busy,
        output e_is_load, e_dst, d_rs, d_rt,
        output d_use_rs, d_use_rt, d_valid,
        output br_taken, br_target, exc_valid, exc_vector,
        input  en_pc, en_fd, en_de, en_em, en_mw,
        input  flush_fd, flush_de, flush_em, flush_mw,
        input  redirect_valid, redirect_pc, drop_fetch
    );

    modport slave (
        input  i_busy, i_data_ok, d_busy, md_busy,
        input  e_is_load, e_dst, d_rs, d_rt,
        input  d_use_rs, d_use_rt, d_valid,
        input  br_taken, br_target, exc_valid, exc_vector,
        output en_pc, en_fd, en_de, en_em, en_mw,
        output flush_fd, flush_de, flush_em, flush_mw,
        output redirect_valid, redirect_pc, drop_fetch
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: stalls, branch
// delay-slot redirects and exceptions with stale-fetch dropping.
module pipe_hazard_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input logic clk,
    input logic resetn,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_DS,
        WAIT_DROP,
        ISSUE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        fetch_stall;
    logic        load_use;
    logic        rs_hit;
    logic        rt_hit;

    assign fetch_stall = hz.i_busy & ~hz.i_data_ok;
    assign rs_hit = hz.d_use_rs & (hz.d_rs == hz.e_dst);
    assign rt_hit = hz.d_use_rt & (hz.d_rt == hz.e_dst);
    assign load_use = hz.e_is_load & (hz.e_dst != 5'd0)
                    & (rs_hit | rt_hit);

    always_comb begin
        hz.en_pc          = 1'b1;
        hz.en_fd          = 1'b1;
        hz.en_de          = 1'b1;
        hz.en_em          = 1'b1;
        hz.en_mw          = 1'b1;
        hz.flush_fd       = 1'b0;
        hz.flush_de       = 1'b0;
        hz.flush_em       = 1'b0;
        hz.flush_mw       = 1'b0;
        hz.redirect_valid = 1'b0;
        hz.redirect_pc    = tgt_q;
        hz.drop_fetch     = 1'b0;
        state_d           = state_q;
        tgt_d             = tgt_q;

        priority case (1'b1)
            hz.d_busy: begin
                hz.en_pc    = 1'b0;
                hz.en_fd    = 1'b0;
                hz.en_de    = 1'b0;
                hz.en_em    = 1'b0;
                hz.flush_mw = 1'b1;
            end
            hz.md_busy: begin
                hz.en_pc    = 1'b0;
                hz.en_fd    = 1'b0;
                hz.en_de    = 1'b0;
                hz.flush_em = 1'b1;
            end
            load_use: begin
                hz.en_pc    = 1'b0;
                hz.en_fd    = 1'b0;
                hz.flush_de = 1'b1;
            end
            fetch_stall: begin
                hz.en_pc    = 1'b0;
                hz.flush_fd = 1'b1;
            end
            default: ;
        endcase

        // No sequential fetch may slip past a pending redirect.
        if (state_q == WAIT_DS || state_q == WAIT_DROP)
            hz.en_pc = 1'b0;

        if (hz.exc_valid) begin
            hz.flush_fd = 1'b1;
            hz.flush_de = 1'b1;
            hz.flush_em = 1'b1;
            hz.flush_mw = 1'b1;
            tgt_d       = hz.exc_vector;
        end

        unique case (state_q)
            IDLE: begin
                if (hz.exc_valid) begin
                    if (fetch_stall) begin
                        state_d = WAIT_DROP;
                    end else begin
                        hz.redirect_valid = 1'b1;
                        hz.redirect_pc    = hz.exc_vector;
                    end
                end else if (hz.br_taken & ~hz.d_busy
                             & ~hz.md_busy) begin
                    hz.flush_fd = 1'b1;
                    tgt_d       = hz.br_target;
                    if (!hz.d_valid) begin
                        state_d = WAIT_DS;
                    end else if (fetch_stall) begin
                        state_d = WAIT_DROP;
                    end else begin
                        hz.redirect_valid = 1'b1;
                        hz.redirect_pc    = hz.br_target;
                    end
                end
            end
            WAIT_DS: begin
                // An exception squashes the delay slot: its
                // response becomes a stale one to drop.
                if (hz.i_data_ok) begin
                    if (hz.exc_valid) begin
                        hz.drop_fetch = 1'b1;
                        hz.flush_fd   = 1'b1;
                    end
                    state_d = ISSUE;
                end else if (hz.exc_valid) begin
                    state_d = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (hz.i_data_ok) begin
                    hz.drop_fetch = 1'b1;
                    hz.flush_fd   = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                hz.redirect_valid = 1'b1;
                if (hz.i_busy)
                    state_d = WAIT_DROP;
                else if (hz.exc_valid)
                    state_d = ISSUE;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end
endmodule
